nibble_serial_add_ctrl: RTL



---
 rtl/nibble_serial_add_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Two-requester arbiter that runs WORD_W-bit additions through one shared
// 4-bit adder, one nibble per cycle, LSB first, and returns {carry, sum}.

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_add_ctrl #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    input  logic              req1_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WORD_W-1:0] rsp_sum,
    output logic              rsp_carry,
    output logic              busy
);
    localparam int NIB   = WORD_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic                carry_q, carry_d;
    logic [IDX_W-1:0]    nib_idx_q, nib_idx_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]   rsp_sum_q, rsp_sum_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic                rsp_id_q, rsp_id_d;
    logic                busy_q, busy_d;

    logic                grant0, grant1;
    logic [3:0]          add_a, add_b, add_sum;
    logic                add_cout;

    // The pointer only breaks ties; a lone valid requester always wins.
    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && (!req0_valid ||  ptr_q);

    assign req0_ready = rst_n && (state_q == IDLE) && grant0;
    assign req1_ready = rst_n && (state_q == IDLE) && grant1;

    always_comb begin
        add_a = 4'h0;
        add_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (nib_idx_q == IDX_W'(i)) begin
                add_a = a_q[4*i +: 4];
                add_b = b_q[4*i +: 4];
            end
        end
    end

    adder_4bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        nib_idx_d   = nib_idx_q;
        result_d    = result_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;

        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d       = grant1 ? req1_a   : req0_a;
                    b_d       = grant1 ? req1_b   : req0_b;
                    carry_d   = grant1 ? req1_cin : req0_cin;
                    id_d      = grant1;
                    ptr_d     = !grant1;
                    nib_idx_d = '0;
                    result_d  = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NIB; i++) begin
                    if (nib_idx_q == IDX_W'(i)) begin
                        result_d[4*i +: 4] = add_sum;
                    end
                end
                carry_d   = add_cout;
                nib_idx_d = nib_idx_q + IDX_W'(1);
                if (nib_idx_q == LAST_IDX) begin
                    nib_idx_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_sum_d   = result_d;
                    rsp_carry_d = add_cout;
                    rsp_id_d    = id_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Returning to IDLE here means the next grant is a cycle later.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            nib_idx_q   <= '0;
            result_q    <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            nib_idx_q   <= nib_idx_d;
            result_q    <= result_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule
